// File: rtl/weight_stream_scheduler_if.sv
// ROM-side and downstream-stream signals of the weight stream scheduler.
// The master side is the scheduler; the slave side is the ROM plus the consumer.
interface weight_stream_scheduler_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;

  modport master (
    output rom_addr, rom_ce, data_out, data_out_valid, data_out_last,
    input  rom_q, data_out_ready
  );

  modport slave (
    input  rom_addr, rom_ce, data_out, data_out_valid, data_out_last,
    output rom_q, data_out_ready
  );
endinterface

// File: rtl/weight_stream_scheduler.sv
// Issues addresses to a fixed-latency parameter ROM, tracks in-flight reads with a tag pipe
// and buffers returned words in a small FIFO feeding a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for start; done pulses here for one cycle after a run
//   RUN   | issuing addresses under the credit rule
//   DRAIN | all addresses issued; waiting for in-flight reads and FIFO to empty
module weight_stream_scheduler #(
  parameter int DATA_WIDTH   = 128,
  parameter int OUT_DEPTH    = 2304,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH) + 1,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int PASS_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  weight_stream_scheduler_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);
  localparam logic [PW-1:0]         LAST_PTR  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [PASS_WIDTH-1:0]   pass_cnt;
  logic [PASS_WIDTH-1:0]   passes;
  logic                    rom_ce_q;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_last;
  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           inflight;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    drain_done;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(tag_vld[i]);
  end

  // Conservative credit: a pop in the same cycle does not free a slot yet.
  assign issue      = (state == RUN) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
  assign push       = tag_vld[READ_LATENCY-1];
  assign pop        = (fifo_count != '0) && bus.data_out_ready;
  assign drain_done = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  assign busy               = (state != IDLE);
  assign bus.rom_addr       = addr_cnt;
  assign bus.rom_ce         = rom_ce_q;
  assign bus.data_out       = fifo_data[rd_ptr];
  assign bus.data_out_valid = (fifo_count != '0);
  assign bus.data_out_last  = (fifo_count != '0) && fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      rom_ce_q <= 1'b0;
      addr_cnt <= '0;
      pass_cnt <= '0;
      passes   <= '0;
    end else begin
      rom_ce_q <= 1'b1;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_passes == '0) begin
              done <= 1'b1;
            end else begin
              state    <= RUN;
              passes   <= num_passes;
              addr_cnt <= '0;
              pass_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (addr_cnt == LAST_ADDR) begin
              addr_cnt <= '0;
              pass_cnt <= pass_cnt + PASS_WIDTH'(1);
              if (pass_cnt == passes - PASS_WIDTH'(1)) state <= DRAIN;
            end else begin
              addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ROM pipe is free-running, so the tag leaving the pipe marks the live rom_q word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld    <= '0;
      tag_last   <= '0;
      fifo_last  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      tag_vld[0]  <= issue;
      tag_last[0] <= issue && (addr_cnt == LAST_ADDR);

      if (push) begin
        fifo_data[wr_ptr] <= bus.rom_q;
        fifo_last[wr_ptr] <= tag_last[READ_LATENCY-1];
        wr_ptr            <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
